// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared FSM/fold types and size helpers for the twiddle sequencer
package twiddle_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} tw_fsm_t;
   typedef enum logic {FOLD_LO, FOLD_HI} fold_t;
   function automatic int log2n(input int n);
      return $clog2(n);
   endfunction
   function automatic int qtr(input int n);
      return n / 4;
   endfunction
endpackage

// File: rtl/twiddle_seq_gen_if.sv
// twiddle_seq_gen_if: valid/ready twiddle stream from sequencer (master) to butterfly datapath (slave)
interface twiddle_seq_gen_if #(
   parameter int DATA_W = 16,
   parameter int SW     = 3
);
   logic              tw_valid;
   logic              tw_ready;
   logic [DATA_W-1:0] tw_re;
   logic [DATA_W-1:0] tw_im;
   logic [SW-1:0]     tw_stage;
   logic              tw_last;
   modport master(output tw_valid, tw_re, tw_im, tw_stage, tw_last, input tw_ready);
   modport slave(input tw_valid, tw_re, tw_im, tw_stage, tw_last, output tw_ready);
endinterface

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: dual-read synchronous quarter-wave cosine ROM, round(2^FRAC_W*cos(2*pi*i/N)), i = 0..N/4
// Contents are generated at elaboration, matching the tw_cos.mem image, so no file dependency exists.
module twiddle_qrom #(
   parameter int  N_FFT  = 64,
   parameter int  DATA_W = 16,
   parameter int  FRAC_W = 8,
   localparam int DEPTH  = N_FFT / 4 + 1,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [AW-1:0]     addr_a,
   input  logic [AW-1:0]     addr_b,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
);
   function automatic logic [DATA_W-1:0] cos_q(input int i);
      real x, t, s;
      x = 6.283185307179586 * real'(i) / real'(N_FFT);
      t = 1.0;
      s = 1.0;
      for (int m = 1; m <= 12; m++) begin
         t = -t * x * x / real'((2 * m - 1) * (2 * m));
         s = s + t;
      end
      return DATA_W'($rtoi(s * (2.0 ** FRAC_W) + 0.5));
   endfunction
   logic [DATA_W-1:0] tbl [DEPTH];
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
      localparam logic [DATA_W-1:0] V = cos_q(i);
      assign tbl[i] = V;
   end
   always_comb begin
      a_d = en ? tbl[addr_a] : a_q;
      b_d = en ? tbl[addr_b] : b_q;
   end
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end
   assign rd_a = a_q;
   assign rd_b = b_q;
endmodule

// File: rtl/twiddle_seq_gen.sv
// twiddle_seq_gen: radix-2 DIF twiddle sequencer, quarter-wave table with symmetry folding.
// Optional TWIDDLE_INV_MODE_EN adds inv_mode to emit conjugated (IFFT) twiddles.
module twiddle_seq_gen
   import twiddle_pkg::*;
#(
   parameter int  N_FFT  = 64,
   parameter int  DATA_W = 16,
   parameter int  FRAC_W = 8,
   localparam int LOG2N  = log2n(N_FFT),
   localparam int SW     = $clog2(LOG2N),
   localparam int Q      = qtr(N_FFT),
   localparam int AW     = $clog2(Q + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
`ifdef TWIDDLE_INV_MODE_EN
   input  logic inv_mode,
`endif
   output logic busy,
   output logic done,
   twiddle_seq_gen_if.master tw
);
   localparam int JW = LOG2N - 1;
   tw_fsm_t           state_q, state_d;
   logic [SW-1:0]     s_q, s_d, p1_stage_q, p1_stage_d, stage_q, stage_d;
   logic [JW-1:0]     j_q, j_d;
   logic [LOG2N-1:0]  k;
   fold_t             fold, p1_fold_q, p1_fold_d;
   logic [AW-1:0]     addr_a, addr_b;
   logic [DATA_W-1:0] rom_a, rom_b, re_q, re_d, im_q, im_d;
   logic              inv_in, inv_q, inv_d, p1_v_q, p1_v_d, p1_last_q, p1_last_d;
   logic              v_q, v_d, last_q, last_d, done_q, done_d;
   logic              adv, issue, last_idx, acc;
`ifdef TWIDDLE_INV_MODE_EN
   assign inv_in = inv_mode;
`else
   assign inv_in = 1'b0;
`endif
   assign adv      = !v_q || tw.tw_ready;
   assign issue    = (state_q == RUN) && adv;
   assign last_idx = (s_q == SW'(LOG2N - 1)) && (j_q == '1);
   assign acc      = v_q && tw.tw_ready && last_q;
   // k = (j mod (N >> (s+1))) << s, folded onto the stored quarter wave
   assign k      = (LOG2N'(j_q) & (LOG2N'(N_FFT / 2 - 1) >> s_q)) << s_q;
   assign fold   = (k > LOG2N'(Q)) ? FOLD_HI : FOLD_LO;
   assign addr_a = AW'((fold == FOLD_HI) ? LOG2N'(N_FFT / 2) - k : k);
   assign addr_b = AW'((fold == FOLD_HI) ? k - LOG2N'(Q) : LOG2N'(Q) - k);
   twiddle_qrom #(.N_FFT(N_FFT), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_rom (
      .clk(clk), .en(adv), .addr_a(addr_a), .addr_b(addr_b), .rd_a(rom_a), .rd_b(rom_b)
   );
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      j_d     = j_q;
      inv_d   = inv_q;
      if (state_q == IDLE && start) begin
         state_d = RUN;
         s_d     = '0;
         j_d     = '0;
         inv_d   = inv_in;
      end
      if (issue) begin
         j_d     = j_q + 1'b1;
         s_d     = (j_q == '1) ? s_q + 1'b1 : s_q;
         state_d = last_idx ? DRAIN : RUN;
      end
      if (state_q == DRAIN && acc) state_d = IDLE;
      p1_v_d     = adv ? issue : p1_v_q;
      p1_last_d  = adv ? issue && last_idx : p1_last_q;
      p1_fold_d  = adv ? fold : p1_fold_q;
      p1_stage_d = adv ? s_q : p1_stage_q;
      v_d        = adv ? p1_v_q : v_q;
      last_d     = adv ? p1_last_q : last_q;
      stage_d    = adv ? p1_stage_q : stage_q;
      re_d       = adv ? ((p1_fold_q == FOLD_HI) ? -rom_a : rom_a) : re_q;
      im_d       = adv ? (inv_q ? rom_b : -rom_b) : im_q;
      done_d     = acc;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         s_q        <= '0;
         j_q        <= '0;
         inv_q      <= 1'b0;
         p1_v_q     <= 1'b0;
         p1_last_q  <= 1'b0;
         p1_fold_q  <= FOLD_LO;
         p1_stage_q <= '0;
         v_q        <= 1'b0;
         last_q     <= 1'b0;
         stage_q    <= '0;
         re_q       <= '0;
         im_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         j_q        <= j_d;
         inv_q      <= inv_d;
         p1_v_q     <= p1_v_d;
         p1_last_q  <= p1_last_d;
         p1_fold_q  <= p1_fold_d;
         p1_stage_q <= p1_stage_d;
         v_q        <= v_d;
         last_q     <= last_d;
         stage_q    <= stage_d;
         re_q       <= re_d;
         im_q       <= im_d;
         done_q     <= done_d;
      end
   end
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign tw.tw_valid = v_q;
   assign tw.tw_re    = re_q;
   assign tw.tw_im    = im_q;
   assign tw.tw_stage = stage_q;
   assign tw.tw_last  = last_q;
endmodule

// File: tb/tb_twiddle_seq_gen.sv
// tb_twiddle_seq_gen: random-backpressure bench with a trigonometric reference model of the twiddle stream
module tb_twiddle_seq_gen;
   localparam int N = 64, DW = 16, LOG2N = 6, SW = 3, TOTAL = LOG2N * N / 2;
   typedef struct packed {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic [SW-1:0] st;
      logic          last;
   } beat_t;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done, inv_mode = 1'b0;
   beat_t exp_q[$];
   beat_t obs [TOTAL];
   beat_t cur, e, held_b;
   int n_cmp = 0, n_err = 0, beats = 0, cyc = 0;
   bit rmode = 1'b0, poke = 1'b0, done_exp = 1'b0, held = 1'b0;
   twiddle_seq_gen_if #(.DATA_W(DW), .SW(SW)) tw();
   twiddle_seq_gen #(.N_FFT(N), .DATA_W(DW), .FRAC_W(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
`ifdef TWIDDLE_INV_MODE_EN
      .inv_mode(inv_mode),
`endif
      .busy(busy),
      .done(done),
      .tw(tw.master)
   );
   always #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask
   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction
   // W_N^k = cos - j*sin (conjugated for inverse), enumerated stage-major
   task automatic push_seq(input bit inv);
      for (int s = 0; s < LOG2N; s++)
         for (int j = 0; j < N / 2; j++) begin
            int k;
            real th;
            beat_t b;
            k    = (j % (N >> (s + 1))) << s;
            th   = 6.283185307179586 * real'(k) / real'(N);
            b.re = DW'(rnd(256.0 * $cos(th)));
            b.im = DW'(inv ? rnd(256.0 * $sin(th)) : -rnd(256.0 * $sin(th)));
            b.st = SW'(s);
            b.last = (s == LOG2N - 1) && (j == N / 2 - 1);
            exp_q.push_back(b);
         end
   endtask
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         exp_q.delete();
         held = 1'b0;
         done_exp = 1'b0;
         tw.tw_ready = 1'b0;
      end else begin
         cur = {tw.tw_re, tw.tw_im, tw.tw_stage, tw.tw_last};
         chk("done", done, done_exp);
         if (held) begin
            chk("stall_valid", tw.tw_valid, held);
            chk("stall_hold", cur, held_b);
         end
         tw.tw_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         done_exp = 1'b0;
         if (tw.tw_valid && tw.tw_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_beat: got beat %0h, expected none", cur);
            end else begin
               e = exp_q.pop_front();
               chk("beat_re", cur.re, e.re);
               chk("beat_im", cur.im, e.im);
               chk("beat_stage", cur.st, e.st);
               chk("beat_last", cur.last, e.last);
               if (beats < TOTAL) obs[beats] = cur;
               beats++;
               done_exp = e.last;
            end
         end
         held = tw.tw_valid && !tw.tw_ready;
         held_b = cur;
      end
   end
   task automatic start_seq(input bit inv, output int c0);
      int lat;
      push_seq(inv);
      inv_mode = inv;
      beats = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start = 1'b0;
      lat = 1;
      while (!tw.tw_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, 3);
   endtask
   task automatic wait_done(output int c);
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) break;
         if (poke && (i % 37 == 5)) start = 1'b1;
      end
      if (i == 3000) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: got no done, expected done within 3000 cycles");
      end
      c = cyc;
   endtask
   task automatic lit_checks();
      chk("beats", beats, TOTAL);
      chk("model_drained", exp_q.size(), 0);
      chk("k0", {obs[0].re, obs[0].im}, 32'h0100_0000);
      chk("k8", {obs[8].re, obs[8].im}, 32'h00B5_FF4B);
      chk("k16", {obs[16].re, obs[16].im}, 32'h0000_FF00);
      chk("k24", {obs[24].re, obs[24].im}, 32'hFF4B_FF4B);
      for (int i = 160; i < TOTAL; i++)
         chk("stage5", {obs[i].re, obs[i].im, obs[i].st}, {16'h0100, 16'h0000, 3'd5});
      chk("last_flag", obs[TOTAL-1].last, 1);
   endtask
   initial begin
      int c0, c1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", tw.tw_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_re", tw.tw_re, 0);
      chk("rst_im", tw.tw_im, 0);
      chk("rst_stage", tw.tw_stage, 0);
      chk("rst_last", tw.tw_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_seq(1'b0, c0);
      wait_done(c1);
      chk("seq_cycles", c1 - c0, 194);
      chk("busy_at_done", busy, 0);
      lit_checks();
      rmode = 1'b1;
      poke = 1'b1;
      start_seq(1'b0, c0);
      wait_done(c1);
      chk("busy_at_done_rand", busy, 0);
      lit_checks();
      rmode = 1'b0;
      poke = 1'b0;
`ifdef TWIDDLE_INV_MODE_EN
      @(negedge clk);
      start_seq(1'b1, c0);
      wait_done(c1);
      chk("inv_k8", {obs[8].re, obs[8].im}, 32'h00B5_00B5);
      chk("inv_k16", {obs[16].re, obs[16].im}, 32'h0000_0100);
      inv_mode = 1'b0;
`endif
      @(negedge clk);
      start_seq(1'b0, c0);
      for (int i = 0; i < 400 && beats < 50; i++) @(negedge clk);
      chk("abort_point", beats >= 50, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_valid", tw.tw_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_re", tw.tw_re, 0);
      chk("abort_last", tw.tw_last, 0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_seq(1'b0, c0);
      wait_done(c1);
      chk("fresh_cycles", c1 - c0, 194);
      lit_checks();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
